regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//   Owns the single write port of the processor register file and the hazard view of it.
//   - Arbitrates NUM_REQ writeback sources (ALU, LSU, ...) onto that port, round-robin.
//   - Keeps a per-register busy scoreboard and stalls issue on RAW/WAW hazards
//     against in-flight writes.
//   - Sits between the issue stage, the execution units and the register file.
// PARAMETERS
//   DATA_WIDTH      32  register data width
//   REGISTERS       32  number of architectural registers; x0 is hardwired zero
//   LOG2_REGISTERS   5  register address width
//   NUM_REQ          2  number of writeback requesters; index 0 has priority after reset
// PORTS
//   clk          in   1                     clock
//   rst          in   1                     reset, synchronous, active-high
//   issue_valid  in   1                     issue stage presents an instruction
//   issue_rs1    in   LOG2_REGISTERS        source register 1
//   issue_rs2    in   LOG2_REGISTERS        source register 2
//   issue_rd     in   LOG2_REGISTERS        destination register (0 = no write)
//   issue_stall  out  1                     hazard; instruction must be held
//   wb_valid     in   NUM_REQ               per-requester write request
//   wb_rd        in   NUM_REQ*LOG2_REGISTERS  per-requester destination, requester i at [i*L+:L]
//   wb_data      in   NUM_REQ*DATA_WIDTH    per-requester data, requester i at [i*DW+:DW]
//   wb_ready     out  NUM_REQ               one-hot grant; transfer when valid && ready
//   rf_addr_rd   out  LOG2_REGISTERS        register file write address
//   rf_data_rd   out  DATA_WIDTH            register file write data
//   busy_o       out  REGISTERS             scoreboard state, for debug
// BEHAVIOUR
// Register file port contract
//   - The register file writes rf_data_rd to rf_addr_rd on every clk edge.
//   - Writes to address 0 are discarded.
//   - Idle cycles therefore MUST drive rf_addr_rd = 0 and rf_data_rd = 0.
// Arbitration (combinational)
//   - Rotating pointer ptr, 0..NUM_REQ-1.
//   - Grant goes to the first i with wb_valid[i], searching ptr, ptr+1, ... modulo NUM_REQ.
//   - wb_ready is one-hot or zero; it never asserts for a requester whose wb_valid is low.
//   - rf_addr_rd/rf_data_rd = granted wb_rd/wb_data in the same cycle.
//   - Zero latency: the register file holds the value after the edge that ends the grant cycle.
//   - On grant of requester g: ptr <= (g+1) mod NUM_REQ.
//   - No grant: ptr is held.
//   - A requester must hold wb_valid/wb_rd/wb_data stable until it sees wb_ready.
// Scoreboard
//   - busy[REGISTERS-1:0]; busy[0] is constant 0.
//   - issue_stall = issue_valid && (busy[issue_rs1] || busy[issue_rs2] || busy[issue_rd]).
//     Computed from registered busy only; it is never bypassed by a same-cycle grant.
//   - Issue accepted when issue_valid && !issue_stall.
//     If issue_rd != 0, busy[issue_rd] <= 1 at the edge.
//   - Write granted to rd != 0: busy[rd] <= 0 at the same edge the register file is written.
//     A following issue reading rd sees the new value.
//   - Accept and grant to different registers in one cycle: both updates apply.
//   - Accept and grant to the same register in one cycle: impossible, because issue
//     stalls on busy rd (WAW).
//   - Granted write to a non-busy register: written normally; scoreboard unchanged.
//   - Granted write to rd = 0: handshake completes; no architectural effect.
// Reset
//   - rst high at an edge: busy <= 0, ptr <= 0.
//   - While rst is high: wb_ready = 0, rf_addr_rd = 0, rf_data_rd = 0,
//     issue_stall = 0, busy_o = 0.
//   - Reset mid-operation drops all in-flight writes. Requesters are reset by the same rst.
// TESTING
//   1. Reset. Issue rd=5; next cycle issue rs1=5.
//      -> second issue stalls until wb from req1 with rd=5, data=0xDEAD is granted.
//      -> stall drops the cycle after the grant; the register file reads 0xDEAD.
//   2. req0 and req1 valid every cycle, rd=3/4.
//      -> grants alternate 0,1,0,1 starting with 0 after reset; no requester waits more than 1 cycle.
//   3. No wb_valid for 10 cycles -> rf_addr_rd = 0 and wb_ready = 0 every cycle.
//   4. Issue rd=7 while req0 writes rd=9 in the same cycle
//      -> busy_o shows bit 7 set and bit 9 clear after the edge.
//   5. Issue rd=0, rs1=0, rs2=0 -> never stalls; busy_o stays 0.
//   6. rst asserted with busy bits set and req0 pending
//      -> busy_o = 0 and wb_ready = 0 next cycle; ptr restarts at 0.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Owns the single write port of the register file and the per-register busy
// scoreboard that the issue stage consults for RAW/WAW hazards.
//   - Round-robin arbitration of NUM_REQ writeback sources onto the port,
//     zero latency: the granted rd/data drive the register file in the same
//     cycle the grant is given.
//   - Scoreboard: issue sets busy[rd], a granted writeback clears it at the
//     same edge the register file is written.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   issue_valid   issue stage presents an instruction
//   issue_rs1/2   source registers
//   issue_rd      destination register (0 = no write)
//   issue_stall   hazard against an in-flight write; hold the instruction
//   wb_valid      per-requester write request
//   wb_rd         per-requester destination, requester i at [i*L +: L]
//   wb_data       per-requester data, requester i at [i*DW +: DW]
//   wb_ready      one-hot grant (or zero)
//   rf_addr_rd    register file write address (0 when idle)
//   rf_data_rd    register file write data (0 when idle)
//   busy_o        scoreboard state
// ---------------------------------------------------------------------------
module regfile_wb_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTERS      = 32,
  parameter int LOG2_REGISTERS = 5,
  parameter int NUM_REQ        = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             issue_valid,
  input  logic [LOG2_REGISTERS-1:0]        issue_rs1,
  input  logic [LOG2_REGISTERS-1:0]        issue_rs2,
  input  logic [LOG2_REGISTERS-1:0]        issue_rd,
  output logic                             issue_stall,
  input  logic [NUM_REQ-1:0]               wb_valid,
  input  logic [NUM_REQ*LOG2_REGISTERS-1:0] wb_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wb_data,
  output logic [NUM_REQ-1:0]               wb_ready,
  output logic [LOG2_REGISTERS-1:0]        rf_addr_rd,
  output logic [DATA_WIDTH-1:0]            rf_data_rd,
  output logic [REGISTERS-1:0]             busy_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so ptr + offset never overflows before the modulo wrap.
  localparam int SUM_W = PTR_W + 1;
  localparam logic [SUM_W-1:0] NUM_REQ_W = SUM_W'(NUM_REQ);

  logic [REGISTERS-1:0]      r_busy;
  logic [REGISTERS-1:0]      w_busy_next;
  logic [PTR_W-1:0]          r_ptr;
  logic [PTR_W-1:0]          w_ptr_next;
  logic [SUM_W-1:0]          w_ptr_sum;
  logic [PTR_W-1:0]          w_cand [NUM_REQ];
  logic                      w_found;
  logic [PTR_W-1:0]          w_gnt_idx;
  logic [NUM_REQ-1:0]        w_grant;
  logic [LOG2_REGISTERS-1:0] w_gnt_rd;
  logic [DATA_WIDTH-1:0]     w_gnt_data;
  logic                      w_stall_raw;
  logic                      w_accept;

  // Search order: candidate k is requester (ptr + k) mod NUM_REQ.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [SUM_W-1:0] w_sum;
      assign w_sum       = {1'b0, r_ptr} + SUM_W'(gi);
      assign w_cand[gi]  = (w_sum >= NUM_REQ_W) ? PTR_W'(w_sum - NUM_REQ_W)
                                                : w_sum[PTR_W-1:0];
    end
  endgenerate

  // First valid requester in rotated order wins.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && wb_valid[w_cand[k]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[k];
      end
    end
  end

  // Grant decode and write-port mux. Idle (or reset) leaves the port at
  // address 0 / data 0 because the register file writes on every edge.
  always_comb begin
    w_grant    = '0;
    w_gnt_rd   = '0;
    w_gnt_data = '0;
    if (w_found && !rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_gnt_idx == PTR_W'(i)) begin
          w_grant[i] = 1'b1;
          w_gnt_rd   = wb_rd[i*LOG2_REGISTERS +: LOG2_REGISTERS];
          w_gnt_data = wb_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Pointer moves to the requester after the one just granted.
  assign w_ptr_sum  = {1'b0, w_gnt_idx} + SUM_W'(1);
  assign w_ptr_next = (w_ptr_sum >= NUM_REQ_W) ? '0 : w_ptr_sum[PTR_W-1:0];

  // Hazard check uses registered busy only; a write granted this cycle is
  // not bypassed, so the stall drops one cycle after the grant.
  assign w_stall_raw = issue_valid &&
                       (r_busy[issue_rs1] || r_busy[issue_rs2] || r_busy[issue_rd]);
  assign w_accept    = !rst && issue_valid && !w_stall_raw;

  // Clear on grant, set on accept. Same-register collisions cannot occur
  // because an issue to a busy rd stalls. Bit 0 is forced to zero, which
  // also makes rd = 0 issues and writebacks architecturally invisible.
  always_comb begin
    w_busy_next = r_busy;
    if (|w_grant) begin
      w_busy_next[w_gnt_rd] = 1'b0;
    end
    if (w_accept) begin
      w_busy_next[issue_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_ptr  <= '0;
    end else begin
      r_busy <= w_busy_next;
      if (|w_grant) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  assign wb_ready    = w_grant;
  assign rf_addr_rd  = w_gnt_rd;
  assign rf_data_rd  = w_gnt_data;
  assign issue_stall = !rst && w_stall_raw;
  assign busy_o      = rst ? '0 : r_busy;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_scheduler
//
// Scoreboard bench: each expected writeback (requester, rd, data) is queued
// when stimulus is issued; a monitor pops and compares whenever the DUT
// grants. Scoreboard/stall/idle checks are made directly by the stimulus.
// ---------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int L  = 5;
  localparam int NQ = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           issue_valid;
  logic [L-1:0]   issue_rs1, issue_rs2, issue_rd;
  logic           issue_stall;
  logic [NQ-1:0]  wb_valid;
  logic [NQ*L-1:0] wb_rd;
  logic [NQ*DW-1:0] wb_data;
  logic [NQ-1:0]  wb_ready;
  logic [L-1:0]   rf_addr_rd;
  logic [DW-1:0]  rf_data_rd;
  logic [NR-1:0]  busy_o;

  regfile_wb_scheduler #(
    .DATA_WIDTH(DW), .REGISTERS(NR), .LOG2_REGISTERS(L), .NUM_REQ(NQ)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_stall(issue_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .rf_addr_rd(rf_addr_rd), .rf_data_rd(rf_data_rd), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          req;
    logic [L-1:0]  rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_cmp = 0;
  int n_err = 0;
  int c0, c1;

  // Environment register file: writes the port every edge, drops address 0.
  logic [DW-1:0] rf_model [NR];
  always @(posedge clk) begin
    if (rst !== 1'b1 && rf_addr_rd != '0) rf_model[rf_addr_rd] <= rf_data_rd;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_wb(input int i, input logic v, input logic [L-1:0] rd, input logic [DW-1:0] d);
    wb_valid[i]       = v;
    wb_rd[i*L +: L]   = rd;
    wb_data[i*DW +: DW] = d;
  endtask

  task automatic set_issue(input logic v, input logic [L-1:0] rs1, input logic [L-1:0] rs2,
                           input logic [L-1:0] rd);
    issue_valid = v;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    issue_rd    = rd;
  endtask

  // Monitor: every grant must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (wb_valid != '0) chk("grant_when_valid", 64'(wb_ready != '0), 64'd1);
      if (wb_ready != '0) begin
        chk("ready_subset_of_valid", 64'(wb_ready & ~wb_valid), 64'd0);
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_grant: got ready=0x%0h addr=%0d expected no grant",
                   wb_ready, rf_addr_rd);
        end else begin
          e = q.pop_front();
          $display("wb grant: ready=0x%0h addr=%0d data=0x%0h", wb_ready, rf_addr_rd, rf_data_rd);
          chk("grant_req", 64'(wb_ready), 64'(1 << e.req));
          chk("rf_addr", 64'(rf_addr_rd), 64'(e.rd));
          chk("rf_data", 64'(rf_data_rd), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    wb_valid = '0; wb_rd = '0; wb_data = '0;
    step();
    // Outputs quiet while in reset, even with requests and issue present.
    set_issue(1'b1, 5'd5, 5'd0, 5'd0);
    set_wb(0, 1'b1, 5'd3, 32'h1111);
    sample();
    chk("rst_ready", 64'(wb_ready), 64'd0);
    chk("rst_addr", 64'(rf_addr_rd), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_stall", 64'(issue_stall), 64'd0);
    step();
    rst = 1'b0;
    set_wb(0, 1'b0, 5'd0, 32'd0);

    // 1: RAW hazard on x5 resolved by req1 writeback.
    set_issue(1'b1, 5'd0, 5'd0, 5'd5);
    sample(); chk("s1_issue_rd5_stall", 64'(issue_stall), 64'd0);
    step();
    set_issue(1'b1, 5'd5, 5'd0, 5'd0);
    sample(); chk("s1_raw_stall", 64'(issue_stall), 64'd1);
    chk("s1_busy5", 64'(busy_o), 64'h20);
    step();
    sample(); chk("s1_raw_stall_hold", 64'(issue_stall), 64'd1);
    step();
    set_wb(1, 1'b1, 5'd5, 32'hDEAD);
    q.push_back('{1, 5'd5, 32'hDEAD});
    sample(); chk("s1_stall_no_bypass", 64'(issue_stall), 64'd1);
    step();
    set_wb(1, 1'b0, 5'd0, 32'd0);
    sample(); chk("s1_stall_released", 64'(issue_stall), 64'd0);
    chk("s1_busy_clear", 64'(busy_o), 64'd0);
    chk("s1_rf5", 64'(rf_model[5]), 64'hDEAD);
    step();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);

    // 2: both requesters always valid; grants alternate starting with 0.
    for (int k = 0; k < 4; k++) begin
      q.push_back('{0, 5'd3, 32'hA000_0000 + 32'(k)});
      q.push_back('{1, 5'd4, 32'hB000_0000 + 32'(k)});
    end
    c0 = 0; c1 = 0;
    for (int n = 0; n < 8; n++) begin
      set_wb(0, 1'b1, 5'd3, 32'hA000_0000 + 32'(c0));
      set_wb(1, 1'b1, 5'd4, 32'hB000_0000 + 32'(c1));
      sample();
      if (wb_ready[0]) c0++;
      if (wb_ready[1]) c1++;
      step();
    end
    set_wb(0, 1'b0, 5'd0, 32'd0);
    set_wb(1, 1'b0, 5'd0, 32'd0);
    chk("s2_req0_count", 64'(c0), 64'd4);
    chk("s2_req1_count", 64'(c1), 64'd4);

    // 3: idle cycles leave the write port at zero.
    for (int n = 0; n < 10; n++) begin
      sample();
      chk("s3_idle_addr", 64'(rf_addr_rd), 64'd0);
      chk("s3_idle_data", 64'(rf_data_rd), 64'd0);
      chk("s3_idle_ready", 64'(wb_ready), 64'd0);
      step();
    end

    // 5: issue with all-zero registers never stalls and never marks busy.
    set_issue(1'b1, 5'd0, 5'd0, 5'd0);
    for (int n = 0; n < 3; n++) begin
      sample();
      chk("s5_zero_stall", 64'(issue_stall), 64'd0);
      chk("s5_zero_busy", 64'(busy_o), 64'd0);
      step();
    end
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);

    // Writeback to x0 from req1: handshake completes, nothing changes.
    set_wb(1, 1'b1, 5'd0, 32'h55);
    q.push_back('{1, 5'd0, 32'h55});
    step();
    set_wb(1, 1'b0, 5'd0, 32'd0);
    sample(); chk("x0_write_busy", 64'(busy_o), 64'd0);
    step();

    // 4: issue rd=7 in the same cycle req0 retires rd=9.
    set_issue(1'b1, 5'd0, 5'd0, 5'd9);
    sample(); chk("s4_issue9_stall", 64'(issue_stall), 64'd0);
    step();
    set_issue(1'b1, 5'd0, 5'd0, 5'd7);
    set_wb(0, 1'b1, 5'd9, 32'h99);
    q.push_back('{0, 5'd9, 32'h99});
    sample(); chk("s4_issue7_stall", 64'(issue_stall), 64'd0);
    chk("s4_busy_before", 64'(busy_o), 64'h200);
    step();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    set_wb(0, 1'b0, 5'd0, 32'd0);
    sample(); chk("s4_busy_after", 64'(busy_o), 64'h80);
    chk("s4_rf9", 64'(rf_model[9]), 64'h99);
    step();

    // 6: reset with busy bits set and req0 pending; ptr is 1 beforehand.
    set_issue(1'b1, 5'd0, 5'd0, 5'd12);
    step();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    sample(); chk("s6_busy_pre", 64'(busy_o), 64'h1080);
    step();
    rst = 1'b1;
    set_wb(0, 1'b1, 5'd20, 32'h2020);
    set_issue(1'b1, 5'd7, 5'd0, 5'd0);
    sample();
    chk("s6_rst_ready", 64'(wb_ready), 64'd0);
    chk("s6_rst_busy", 64'(busy_o), 64'd0);
    chk("s6_rst_stall", 64'(issue_stall), 64'd0);
    chk("s6_rst_addr", 64'(rf_addr_rd), 64'd0);
    chk("s6_rst_data", 64'(rf_data_rd), 64'd0);
    step();
    rst = 1'b0;
    set_wb(0, 1'b0, 5'd0, 32'd0);
    sample();
    chk("s6_post_busy", 64'(busy_o), 64'd0);
    chk("s6_post_ready", 64'(wb_ready), 64'd0);
    chk("s6_post_stall_rs7", 64'(issue_stall), 64'd0);
    step();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    q.push_back('{0, 5'd21, 32'hC1});
    q.push_back('{1, 5'd22, 32'hC2});
    c0 = 0; c1 = 0;
    for (int n = 0; n < 2; n++) begin
      set_wb(0, c0 == 0, 5'd21, 32'hC1);
      set_wb(1, c1 == 0, 5'd22, 32'hC2);
      sample();
      if (wb_ready[0]) c0++;
      if (wb_ready[1]) c1++;
      step();
    end
    set_wb(0, 1'b0, 5'd0, 32'd0);
    set_wb(1, 1'b0, 5'd0, 32'd0);
    chk("s6_req0_done", 64'(c0), 64'd1);
    chk("s6_req1_done", 64'(c1), 64'd1);

    step();
    step();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
